// File: rtl/fixed_point_pkg.sv
// Shared types and elaboration helpers for the fixed-point MAC.
// Optional saturation is selected with FIXED_POINT_MAC_SATURATE_EN.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        OUT
    } mac_state_e;

    function automatic int unsigned acc_width(int unsigned width, int unsigned acc_guard);
        return 2 * width + acc_guard;
    endfunction

    // Rounding offset: half an LSB of the result
    function automatic int unsigned round_half(int unsigned frac_width);
        return 32'd1 << (frac_width - 1);
    endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Combinational round-half-up and rescale of the accumulator to the result format.
// With FIXED_POINT_MAC_SATURATE_EN defined the result is clamped and ovf_o reports it.
module mac_round_sat
    import fixed_point_pkg::*;
#(
    parameter int unsigned INTEGERWIDTH  = 4,
    parameter int unsigned FRACTIONWIDTH = 4,
    parameter int unsigned ACCW          = 20
) (
    input  logic [ACCW-1:0]                       acc_i,
    output logic [INTEGERWIDTH+FRACTIONWIDTH-1:0] result_o,
    output logic                                  ovf_o
);

    localparam int unsigned W  = INTEGERWIDTH + FRACTIONWIDTH;
    localparam int unsigned RW = ACCW + 1 - FRACTIONWIDTH;
    localparam logic [ACCW:0] Half = (ACCW + 1)'(round_half(FRACTIONWIDTH));

    logic [ACCW:0]        sum;
    logic signed [RW-1:0] r;
    logic                 unused_bits;

    // One extra bit so the rounding offset cannot wrap the largest accumulator
    assign sum = {acc_i[ACCW-1], acc_i} + Half;
    assign r   = $signed(sum[ACCW:FRACTIONWIDTH]);

`ifdef FIXED_POINT_MAC_SATURATE_EN
    localparam logic signed [RW-1:0] MaxR = RW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [RW-1:0] MinR = ~MaxR;

    always_comb begin
        result_o = r[W-1:0];
        ovf_o    = 1'b0;
        if (r > MaxR) begin
            result_o = MaxR[W-1:0];
            ovf_o    = 1'b1;
        end else if (r < MinR) begin
            result_o = MinR[W-1:0];
            ovf_o    = 1'b1;
        end
    end

    assign unused_bits = ^sum[FRACTIONWIDTH-1:0];
`else
    assign result_o    = r[W-1:0];
    assign ovf_o       = 1'b0;
    assign unused_bits = ^{sum[FRACTIONWIDTH-1:0], r[RW-1:W]};
`endif

endmodule

// File: rtl/fixed_point_mac.sv
// Pipelined signed fixed-point multiply-accumulate, one rounded result per frame.
// Define FIXED_POINT_MAC_SATURATE_EN to clamp results instead of wrapping.
module fixed_point_mac
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned INTEGERWIDTH  = 4,
    parameter int unsigned FRACTIONWIDTH = 4,
    parameter int unsigned ACC_LEN       = 4,
    parameter int unsigned ACC_GUARD     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf
);

    localparam int unsigned ACCW = acc_width(WIDTH, ACC_GUARD);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CntW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ACC_LEN - 1);

    mac_state_e       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic             prod_valid_q, prod_valid_d;
    logic             p_last_q, p_last_d;
    logic [ACCW-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic signed [PW-1:0] a_ext, b_ext;
    logic [ACCW-1:0]      acc_sum;
    logic [WIDTH-1:0]     rs_result;
    logic                 rs_ovf;
    logic                 in_fire, last_beat;

    assign a_ext   = $signed({{WIDTH{in_a[WIDTH-1]}}, in_a});
    assign b_ext   = $signed({{WIDTH{in_b[WIDTH-1]}}, in_b});
    assign acc_sum = acc_q + {{ACC_GUARD{prod_q[PW-1]}}, prod_q};

    // Rounding sees the accumulator including the product still in flight
    mac_round_sat #(
        .INTEGERWIDTH (INTEGERWIDTH),
        .FRACTIONWIDTH(FRACTIONWIDTH),
        .ACCW         (ACCW)
    ) u_round (
        .acc_i   (acc_sum),
        .result_o(rs_result),
        .ovf_o   (rs_ovf)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        prod_d       = prod_q;
        prod_valid_d = 1'b0;
        p_last_d     = p_last_q;
        acc_d        = acc_q;
        result_d     = result_q;
        ovf_d        = ovf_q;

        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == OUT);
        in_fire   = in_valid && in_ready;
        last_beat = in_last || (count_q == CntMax);

        if (prod_valid_q) begin
            acc_d = acc_sum;
        end

        if (in_fire) begin
            prod_d       = PW'(a_ext * b_ext);
            prod_valid_d = 1'b1;
            p_last_d     = last_beat;
            count_d      = last_beat ? '0 : count_q + 1'b1;
        end

        unique case (state_q)
            ACCUM: begin
                if (in_fire && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (prod_valid_q && p_last_q) begin
                    result_d = rs_result;
                    ovf_d    = rs_ovf;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            count_q      <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            p_last_q     <= 1'b0;
            acc_q        <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            p_last_q     <= p_last_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_result = result_q;
    assign out_ovf    = ovf_q;

endmodule
